// File: rtl/cdb_arbiter.sv
// Multi-source common data bus: per-source result FIFOs, round-robin grant, registered broadcast.
// Optional build macro CDB_PRIO0_EN gives source 0 fixed priority over the round-robin.

module cdb_queue #(
    parameter int ROB_W  = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [ROB_W-1:0]  in_rob,
    input  logic [DATA_W-1:0] in_data,
    output logic              ready,
    output logic              empty,
    output logic [ROB_W-1:0]  head_rob,
    output logic [DATA_W-1:0] head_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][ROB_W-1:0]  rob_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic [PTR_W-1:0]             rd_ptr, wr_ptr;
    logic [CNT_W-1:0]             count;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            rob_mem[wr_ptr]  <= in_rob;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Flush empties the queue and overrides any push/pop in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign ready     = (count != CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_rob  = rob_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
endmodule

module cdb_arbiter #(
    parameter  int NUM_SRC = 4,
    parameter  int ROB_W   = 6,
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 2,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        req_valid,
    input  logic [NUM_SRC*ROB_W-1:0]  req_rob,
    input  logic [NUM_SRC*DATA_W-1:0] req_data,
    output logic [NUM_SRC-1:0]        req_ready,
    output logic                      cast_valid,
    output logic [ROB_W-1:0]          cast_rob,
    output logic [DATA_W-1:0]         cast_data,
    output logic [SRC_W-1:0]          cast_src
);
    logic [NUM_SRC-1:0]             q_empty;
    logic [NUM_SRC-1:0]             grant;
    logic [NUM_SRC-1:0][ROB_W-1:0]  head_rob;
    logic [NUM_SRC-1:0][DATA_W-1:0] head_data;
    logic [SRC_W-1:0]               rr_ptr, ptr_nxt, win, idx_w;
    logic                           win_vld;
    int unsigned                    idx;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_q
        cdb_queue #(.ROB_W(ROB_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_q (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .push      (req_valid[i] & req_ready[i]),
            .pop       (grant[i]),
            .in_rob    (req_rob[i*ROB_W +: ROB_W]),
            .in_data   (req_data[i*DATA_W +: DATA_W]),
            .ready     (req_ready[i]),
            .empty     (q_empty[i]),
            .head_rob  (head_rob[i]),
            .head_data (head_data[i])
        );
    end

    // Scan from the pointer, wrapping; first non-empty queue wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx_w = SRC_W'(idx);
            if (!win_vld && !q_empty[idx_w]) begin
                win_vld = 1'b1;
                win     = idx_w;
            end
        end
        ptr_nxt = rr_ptr;
        if (win_vld) ptr_nxt = (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + SRC_W'(1);
`ifdef CDB_PRIO0_EN
        if (!q_empty[0]) begin
            win_vld = 1'b1;
            win     = '0;
            ptr_nxt = rr_ptr;
        end
`endif
        grant = '0;
        if (win_vld) grant[win] = 1'b1;
    end

    // A grant in a flush cycle is dropped: queues clear and no broadcast follows.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            cast_valid <= 1'b0;
            cast_rob   <= '0;
            cast_data  <= '0;
            cast_src   <= '0;
        end else if (flush) begin
            rr_ptr     <= '0;
            cast_valid <= 1'b0;
        end else begin
            rr_ptr     <= ptr_nxt;
            cast_valid <= win_vld;
            if (win_vld) begin
                cast_rob  <= head_rob[win];
                cast_data <= head_data[win];
                cast_src  <= win;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expected sequences follow CDB_PRIO0_EN when defined.

module tb_cdb_arbiter;
    localparam int NS = 4;
    localparam int RW = 6;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset, flush;
    logic [NS-1:0]     req_valid;
    logic [NS*RW-1:0]  req_rob;
    logic [NS*DW-1:0]  req_data;
    logic [NS-1:0]     req_ready;
    logic              cast_valid;
    logic [RW-1:0]     cast_rob;
    logic [DW-1:0]     cast_data;
    logic [1:0]        cast_src;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_SRC(NS), .ROB_W(RW), .DATA_W(DW), .DEPTH(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_rob    (req_rob),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cast_valid (cast_valid),
        .cast_rob   (cast_rob),
        .cast_data  (cast_data),
        .cast_src   (cast_src)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] dv(input logic [RW-1:0] rob);
        return 32'hC0DE_0000 | {26'h0, rob};
    endfunction

    task automatic drive(input int s, input logic [RW-1:0] rob, input logic [DW-1:0] data);
        req_valid[s]            = 1'b1;
        req_rob[s*RW +: RW]     = rob;
        req_data[s*DW +: DW]    = data;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic expect_cast(input string tag, input logic [1:0] src, input logic [RW-1:0] rob,
                               input logic [DW-1:0] data);
        chk({tag, "_valid"}, cast_valid, 1'b1);
        chk({tag, "_src"},   cast_src,   src);
        chk({tag, "_rob"},   cast_rob,   rob);
        chk({tag, "_data"},  cast_data,  data);
    endtask

    logic [RW-1:0] bp_rob [3] = '{6'd10, 6'd11, 6'd12};
    logic [RW-1:0] got_q [$];

`ifdef CDB_PRIO0_EN
    logic [1:0]    pr_src [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic [RW-1:0] pr_rob [4] = '{6'd8, 6'd9, 6'd16, 6'd17};
`else
    logic [1:0]    pr_src [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [RW-1:0] pr_rob [4] = '{6'd8, 6'd16, 6'd9, 6'd17};
`endif

    initial begin
        req_rob  = '0;
        req_data = '0;

        // reset then idle
        do_reset;
        chk("rst_ready", req_ready, 4'hF);
        chk("rst_src",   cast_src,  2'd0);
        chk("rst_rob",   cast_rob,  6'd0);
        chk("rst_data",  cast_data, 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("idle_valid", cast_valid, 1'b0);
        end
        chk("idle_ready", req_ready, 4'hF);

        // single result from source 2
        do_reset;
        drive(2, 6'h05, 32'hDEADBEEF);
        tick;
        req_valid = '0;
        chk("single_t_valid", cast_valid, 1'b0);
        tick;
        expect_cast("single", 2'd2, 6'h05, 32'hDEADBEEF);
        tick;
        chk("single_after_valid", cast_valid, 1'b0);
        chk("single_hold_rob",    cast_rob,   6'h05);

        // fairness: all four push together
        do_reset;
        for (int s = 0; s < NS; s++) drive(s, RW'(s + 1), dv(RW'(s + 1)));
        tick;
        req_valid = '0;
        for (int k = 0; k < NS; k++) begin
            tick;
            expect_cast("fair", 2'(k), RW'(k + 1), dv(RW'(k + 1)));
        end
        drive(1, 6'd6, dv(6'd6));
        drive(3, 6'd7, dv(6'd7));
        tick;
        req_valid = '0;
        chk("fair_gap_valid", cast_valid, 1'b0);
        tick;
        expect_cast("fair2_a", 2'd1, 6'd6, dv(6'd6));
        tick;
        expect_cast("fair2_b", 2'd3, 6'd7, dv(6'd7));

        // back-pressure: source 0 kept busy, source 1 pushes 10,11,12
        do_reset;
        begin
            int  i1 = 0;
            int  r0 = 32;
            logic acc0, acc1;
            got_q.delete();
            for (int c = 0; c < 12; c++) begin
                drive(0, RW'(r0), dv(RW'(r0)));
                if (i1 < 3) drive(1, bp_rob[i1], dv(bp_rob[i1]));
                else req_valid[1] = 1'b0;
                acc0 = req_ready[0];
                acc1 = req_valid[1] && req_ready[1];
                tick;
                if (acc0) r0++;
                if (acc1) i1++;
                if (cast_valid && cast_src == 2'd1) got_q.push_back(cast_rob);
                if (c == 1) chk("bp_full_ready1", req_ready[1], 1'b0);
            end
            req_valid = '0;
`ifdef CDB_PRIO0_EN
            chk("bp_held_idx",    i1,            2);
            chk("bp_ready1_low",  req_ready[1],  1'b0);
            chk("bp_no_src1",     got_q.size(),  0);
`else
            chk("bp_accepts",     i1,            3);
            chk("bp_count",       got_q.size(),  3);
            if (got_q.size() == 3) begin
                chk("bp_order0", got_q[0], 6'd10);
                chk("bp_order1", got_q[1], 6'd11);
                chk("bp_order2", got_q[2], 6'd12);
            end
`endif
        end

        // flush mid-stream
        do_reset;
        drive(0, 6'd20, dv(6'd20));
        drive(3, 6'd23, dv(6'd23));
        tick;
        drive(0, 6'd21, dv(6'd21));
        drive(3, 6'd24, dv(6'd24));
        tick;
        req_valid = '0;
        expect_cast("flush_first", 2'd0, 6'd20, dv(6'd20));
        flush = 1'b1;
        drive(2, 6'd40, dv(6'd40));
        tick;
        flush     = 1'b0;
        req_valid = '0;
        chk("flush_valid", cast_valid, 1'b0);
        chk("flush_ready", req_ready,  4'hF);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("flush_quiet_valid", cast_valid, 1'b0);
        end
        drive(3, 6'd25, dv(6'd25));
        tick;
        req_valid = '0;
        chk("flush_new_lat_valid", cast_valid, 1'b0);
        tick;
        expect_cast("flush_new", 2'd3, 6'd25, dv(6'd25));

        // priority / interleave between sources 0 and 1
        do_reset;
        drive(0, 6'd8,  dv(6'd8));
        drive(1, 6'd16, dv(6'd16));
        tick;
        drive(0, 6'd9,  dv(6'd9));
        drive(1, 6'd17, dv(6'd17));
        tick;
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick;
            expect_cast("prio", pr_src[k], pr_rob[k], dv(pr_rob[k]));
        end
        tick;
        chk("prio_end_valid", cast_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
